store_narrow_unit: RTL and testbench

- Store-side counterpart to the load/immediate extension path: it narrows 32-bit register data to byte or halfword, steers it onto the correct little-endian byte lanes, and generates byte enables.
- Sits between the EX/MEM store issue point and the data-memory write port.
- Decouples the two sides with a small FIFO store buffer, using valid/ready handshakes on both sides.

---
 rtl/mips_mem_pkg.sv | 33 +++
 rtl/store_lane_fmt.sv | 32 +++
 rtl/store_narrow_unit.sv | 119 +++++++++++
 tb/tb_store_narrow_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared store-path types: access-size encodings, the buffered store entry,
// and the alignment predicate used when misaligned-store trapping is built in.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } store_size_e;

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] wdata;
    logic [3:0]              be;
  } store_entry_t;

  // Reserved size behaves as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic result;
    result = 1'b0;
    case (store_size_e'(size))
      SIZE_BYTE: result = 1'b0;
      SIZE_HALF: result = addr_lo[0];
      default:   result = (addr_lo != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: replicates narrow data across the byte lanes
// and derives little-endian byte enables from the low address bits and size.
module store_lane_fmt
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be
);

  always_comb begin
    wdata = data;
    be    = 4'b1111;
    case (store_size_e'(size))
      SIZE_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        wdata = {2{data[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = data;
        be    = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: formats stores on push and buffers them in a small FIFO
// ahead of the data-memory write port. Optional trap: STORE_MISALIGN_TRAP_EN.
module store_narrow_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     misalign_err,
  output logic [ADDR_W-1:0]        err_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  store_entry_t     entry_reg [DEPTH];
  store_entry_t     new_entry, head;
  logic [31:0]      fmt_wdata;
  logic [3:0]       fmt_be;
  logic             accept, misaligned, push, pop;

  store_lane_fmt u_fmt (
    .addr_lo (st_addr[1:0]),
    .size    (st_size),
    .data    (st_data),
    .wdata   (fmt_wdata),
    .be      (fmt_be)
  );

  // Ready depends on occupancy only, so a pop never opens a slot in the same cycle.
  assign st_ready  = (count_reg != CNT_W'(DEPTH));
  assign mem_valid = (count_reg != '0);
  assign accept    = st_valid && st_ready;
  assign push      = accept && !misaligned;
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.addr  = ENTRY_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00});
    new_entry.wdata = fmt_wdata;
    new_entry.be    = fmt_be;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg[gi] <= new_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head stays put until popped, which keeps mem_* stable under backpressure.
  assign head      = entry_reg[rd_ptr_reg];
  assign mem_addr  = ADDR_W'(head.addr);
  assign mem_wdata = DATA_W'(head.wdata);
  assign mem_be    = head.be;
  assign buf_count = count_reg;

`ifdef STORE_MISALIGN_TRAP_EN
  logic              misalign_err_reg;
  logic [ADDR_W-1:0] err_addr_reg;

  assign misaligned = is_misaligned(st_size, st_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err_reg <= 1'b0;
      err_addr_reg     <= '0;
    end else begin
      misalign_err_reg <= accept && misaligned;
      if (accept && misaligned) err_addr_reg <= st_addr;
    end
  end

  assign misalign_err = misalign_err_reg;
  assign err_addr     = err_addr_reg;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
  assign err_addr     = '0;
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed self-checking bench for store_narrow_unit (honours STORE_MISALIGN_TRAP_EN).
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  buf_count;
  logic        misalign_err;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_fails  = 0;

  store_narrow_unit #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .buf_count    (buf_count),
    .misalign_err (misalign_err),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  // Backpressure table: stores and their hand-formatted results.
  logic [31:0] bp_addr  [4] = '{32'h0000_0101, 32'h0000_0106, 32'h0000_0108, 32'h0000_010C};
  logic [31:0] bp_data  [4] = '{32'hDEAD_BE11, 32'hA5A5_2222, 32'h3333_3333, 32'h0000_0044};
  logic [1:0]  bp_size  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  logic [31:0] bp_maddr [4] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
  logic [31:0] bp_wdata [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [3:0]  bp_be    [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b0001};

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ready = 1'b0;
    #3;
    check_val("rst_st_ready", st_ready, 1);
    check_val("rst_mem_valid", mem_valid, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_mem_be", mem_be, 0);
    check_val("rst_buf_count", buf_count, 0);
    check_val("rst_misalign_err", misalign_err, 0);
    check_val("rst_err_addr", err_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Byte store to lane 3
    mem_ready = 1'b1;
    set_store(32'h0000_1003, 32'hAABB_CC5A, 2'b00);
    check_val("byte_no_bypass", mem_valid, 0);
    @(negedge clk); st_valid = 1'b0;
    $display("txn byte addr=%h wdata=%h be=%b", mem_addr, mem_wdata, mem_be);
    check_val("byte_valid", mem_valid, 1);
    check_val("byte_addr", mem_addr, 32'h0000_1000);
    check_val("byte_wdata", mem_wdata, 32'h5A5A_5A5A);
    check_val("byte_be", mem_be, 4'b1000);
    @(negedge clk);
    check_val("byte_drained", buf_count, 0);

    // Upper half store
    set_store(32'h0000_2002, 32'h1234_BEEF, 2'b01);
    @(negedge clk); st_valid = 1'b0;
    $display("txn half addr=%h wdata=%h be=%b", mem_addr, mem_wdata, mem_be);
    check_val("half_addr", mem_addr, 32'h0000_2000);
    check_val("half_wdata", mem_wdata, 32'hBEEF_BEEF);
    check_val("half_be", mem_be, 4'b1100);
    @(negedge clk);

    // Word store
    set_store(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
    @(negedge clk); st_valid = 1'b0;
    $display("txn word addr=%h wdata=%h be=%b", mem_addr, mem_wdata, mem_be);
    check_val("word_addr", mem_addr, 32'h0000_3000);
    check_val("word_wdata", mem_wdata, 32'hCAFE_F00D);
    check_val("word_be", mem_be, 4'b1111);
    @(negedge clk);
    check_val("word_drained", buf_count, 0);

    // Backpressure: fill to DEPTH with the memory stalled
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_store(bp_addr[k], bp_data[k], bp_size[k]);
      @(negedge clk);
    end
    st_valid = 1'b0;
    check_val("bp_count_full", buf_count, 4);
    check_val("bp_ready_low", st_ready, 0);
    check_val("bp_head_addr", mem_addr, bp_maddr[0]);
    set_store(32'h0000_0F00, 32'hFFFF_FFFF, 2'b10);
    @(negedge clk); st_valid = 1'b0;
    check_val("bp_full_no_push", buf_count, 4);
    check_val("bp_stable_addr", mem_addr, bp_maddr[0]);
    check_val("bp_stable_wdata", mem_wdata, bp_wdata[0]);
    check_val("bp_stable_be", mem_be, bp_be[0]);
    // A pop while full must not let a push in that same cycle
    mem_ready = 1'b1;
    set_store(32'h0000_0F00, 32'hFFFF_FFFF, 2'b10);
    for (int k = 0; k < 4; k++) begin
      $display("txn drain %0d addr=%h wdata=%h be=%b", k, mem_addr, mem_wdata, mem_be);
      check_val($sformatf("drain%0d_addr", k), mem_addr, bp_maddr[k]);
      check_val($sformatf("drain%0d_wdata", k), mem_wdata, bp_wdata[k]);
      check_val($sformatf("drain%0d_be", k), mem_be, bp_be[k]);
      @(negedge clk);
      st_valid = 1'b0;
      if (k == 0) begin
        check_val("drain_ready_back", st_ready, 1);
        check_val("full_pop_no_push", buf_count, 3);
      end
    end
    check_val("drain_empty", buf_count, 0);
    check_val("drain_valid_low", mem_valid, 0);

    // Simultaneous push and pop at count 2
    mem_ready = 1'b0;
    set_store(32'h0000_5000, 32'h0000_0001, 2'b10); @(negedge clk);
    set_store(32'h0000_5004, 32'h0000_0002, 2'b10); @(negedge clk);
    check_val("pp_count_pre", buf_count, 2);
    set_store(32'h0000_5008, 32'h0000_0003, 2'b10);
    mem_ready = 1'b1;
    @(negedge clk); st_valid = 1'b0;
    check_val("pp_count_kept", buf_count, 2);
    check_val("pp_head_addr", mem_addr, 32'h0000_5004);
    @(negedge clk);
    check_val("pp_next_addr", mem_addr, 32'h0000_5008);
    @(negedge clk);
    check_val("pp_drained", buf_count, 0);

    // Wrap: 10 word stores with random memory readiness
    begin
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      while (recv < 10 && cyc < 400) begin
        st_valid  = (sent < 10);
        st_addr   = 32'h0000_4000 + 32'(sent * 4);
        st_data   = 32'h1000_0000 + 32'(sent);
        st_size   = 2'b10;
        mem_ready = 1'($urandom_range(0, 1));
        if (mem_valid && mem_ready) begin
          $display("txn wrap pop %0d addr=%h wdata=%h", recv, mem_addr, mem_wdata);
          check_val($sformatf("wrap%0d_addr", recv), mem_addr, 32'h0000_4000 + 32'(recv * 4));
          check_val($sformatf("wrap%0d_wdata", recv), mem_wdata, 32'h1000_0000 + 32'(recv));
          recv++;
        end
        if (st_valid && st_ready) sent++;
        cyc++;
        @(negedge clk);
      end
      st_valid = 1'b0; mem_ready = 1'b0;
      check_val("wrap_all_received", recv, 10);
      check_val("wrap_empty", buf_count, 0);
    end

    // Misaligned half at 0x1001
    mem_ready = 1'b1;
    set_store(32'h0000_1001, 32'h0000_CAFE, 2'b01);
    @(negedge clk); st_valid = 1'b0;
    $display("txn misalign half count=%0d err=%b err_addr=%h be=%b", buf_count, misalign_err, err_addr, mem_be);
`ifdef STORE_MISALIGN_TRAP_EN
    check_val("mis_err_pulse", misalign_err, 1);
    check_val("mis_err_addr", err_addr, 32'h0000_1001);
    check_val("mis_not_queued", buf_count, 0);
    @(negedge clk);
    check_val("mis_err_cleared", misalign_err, 0);
    check_val("mis_err_addr_held", err_addr, 32'h0000_1001);
`else
    check_val("mis_queued", buf_count, 1);
    check_val("mis_addr", mem_addr, 32'h0000_1000);
    check_val("mis_wdata", mem_wdata, 32'hCAFE_CAFE);
    check_val("mis_be", mem_be, 4'b0011);
    check_val("mis_no_err", misalign_err, 0);
    check_val("mis_err_addr_zero", err_addr, 0);
    @(negedge clk);
`endif

    // Reset in the middle of traffic
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_store(32'h0000_6000 + 32'(k * 4), 32'h7700_0000 + 32'(k), 2'b10);
      @(negedge clk);
    end
    st_valid = 1'b0;
    check_val("mid_count_pre", buf_count, 3);
    rst_n = 1'b0;
    #1;
    $display("txn mid-reset count=%0d mem_valid=%b", buf_count, mem_valid);
    check_val("mid_valid_low", mem_valid, 0);
    check_val("mid_count_zero", buf_count, 0);
    check_val("mid_be_zero", mem_be, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", st_ready, 1);
    check_val("post_rst_valid", mem_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
